// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction-memory fetch responder:
// FSM encoding, the NOP returned on errors and the error-cause codes.
package imem_fetch_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR_C = 32'h00000013;

    // Error causes in evaluation priority order; kept as a signal for waveform debug.
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_MISALIGN  = 3'd1;
    localparam logic [2:0] ERR_RANGE     = 3'd2;
    localparam logic [2:0] ERR_UNWRITTEN = 3'd3;
    localparam logic [2:0] ERR_PARITY    = 3'd4;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_parity_array.sv
// DEPTH x 33-bit instruction storage (data + even parity) with per-word written
// flags. Synchronous write, combinational read.
module imem_parity_array
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic              fault_inject_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic              rd_parity_o,
    output logic              rd_written_o
);

    logic [32:0]      mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic             wr_parity;

    // A fault inject flips the stored parity so the read side sees a mismatch.
    assign wr_parity = even_parity(wr_data_i) ^ fault_inject_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
        end else if (wr_en_i) begin
            written_q[wr_addr_i] <= 1'b1;
        end
    end

    // NOTE: the data array deliberately has no reset; the written flags make
    // uninitialised contents unobservable, and a reset would stop RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= {wr_parity, wr_data_i};
        end
    end

    assign rd_data_o    = mem_q[rd_addr_i][31:0];
    assign rd_parity_o  = mem_q[rd_addr_i][32];
    assign rd_written_o = written_q[rd_addr_i];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: valid/ready request, fixed programmable
// latency, NOP + error flag on misaligned, out-of-range, unwritten or corrupt words.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic              resp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              fault_inject,
    output logic [7:0]        err_count
);

    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_instr_q;
    logic        resp_err_q;
    logic [7:0]  err_count_q;

    logic [31:0] rd_data;
    logic        rd_parity;
    logic        rd_written;
    logic [2:0]  err_cause_d;
    logic        resp_err_d;
    logic [31:0] resp_instr_d;

    imem_parity_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .fault_inject_i (fault_inject),
        .rd_addr_i      (addr_q[ADDR_W+1:2]),
        .rd_data_o      (rd_data),
        .rd_parity_o    (rd_parity),
        .rd_written_o   (rd_written)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        err_cause_d = ERR_NONE;
        if (addr_q[1:0] != 2'b00) begin
            err_cause_d = ERR_MISALIGN;
        end else if (addr_q[31:2] >= WORD_LIMIT) begin
            err_cause_d = ERR_RANGE;
        end else if (!rd_written) begin
            err_cause_d = ERR_UNWRITTEN;
        end else if (rd_parity != even_parity(rd_data)) begin
            err_cause_d = ERR_PARITY;
        end
        resp_err_d   = (err_cause_d != ERR_NONE);
        resp_instr_d = resp_err_d ? NOP_INSTR : rd_data;
    end

    // NOTE: state and registered outputs use non-blocking assignments only, so
    // every read in this block sees the pre-edge value (this also gives the
    // read-before-write behaviour against a same-edge array write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            resp_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        cnt_q       <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        resp_instr_q <= resp_instr_d;
                        resp_err_q   <= resp_err_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                        if (resp_err_q && (err_count_q != ERR_COUNT_MAX)) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_instr_q;
    assign resp_err   = resp_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: directed scenarios plus random
// traffic checked against a word-level behavioural model of the memory.
module tb_imem_fetch_responder;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned LATENCY = 2;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [31:0]       resp_instr;
    logic              resp_err;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic              fault_inject = 1'b0;
    logic [7:0]        err_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model: word contents, written flag, corrupted flag, delivered errors.
    logic [31:0] m_data [DEPTH];
    bit          m_wr   [DEPTH];
    bit          m_bad  [DEPTH];
    int          m_errs = 0;

    imem_fetch_responder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .LATENCY   (LATENCY),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_instr   (resp_instr),
        .resp_err     (resp_err),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .fault_inject (fault_inject),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_wr[i]  = 1'b0;
            m_bad[i] = 1'b0;
        end
        m_errs = 0;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input bit f);
        m_data[idx] = d;
        m_wr[idx]   = 1'b1;
        m_bad[idx]  = f;
    endfunction

    function automatic void model_eval(input logic [31:0] a, output logic err,
                                       output logic [31:0] ins);
        int unsigned w;
        w   = a >> 2;
        err = 1'b1;
        ins = NOP;
        if (a[1:0] == 2'b00 && w < DEPTH) begin
            if (m_wr[w] && !m_bad[w]) begin
                err = 1'b0;
                ins = m_data[w];
            end
        end
    endfunction

    task automatic write_word(input int idx, input logic [31:0] d, input bit f);
        wr_en        = 1'b1;
        wr_addr      = ADDR_W'(idx);
        wr_data      = d;
        fault_inject = f;
        tick();
        wr_en        = 1'b0;
        fault_inject = 1'b0;
        model_write(idx, d, f);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_err_count", {24'b0, err_count}, 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One complete fetch. Optionally drives a write during WAIT cycle wr_cyc
    // (cycle LATENCY-1 lands on the evaluation edge) and stalls resp_ready for hold cycles.
    task automatic fetch(input logic [31:0] a, input int hold, input bit do_wr,
                         input int wr_cyc, input int wa, input logic [31:0] wd, input bit wf);
        logic        e_err;
        logic [31:0] e_ins;
        e_err = 1'b1;
        e_ins = NOP;
        req_valid  = 1'b1;
        req_addr   = a;
        resp_ready = 1'b0;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        for (int c = 0; c < LATENCY; c++) begin
            check("req_ready_wait", {31'b0, req_ready}, 32'd0);
            check("resp_valid_early", {31'b0, resp_valid}, 32'd0);
            if (do_wr && c == wr_cyc) begin
                wr_en        = 1'b1;
                wr_addr      = ADDR_W'(wa);
                wr_data      = wd;
                fault_inject = wf;
            end
            if (c == LATENCY - 1) model_eval(a, e_err, e_ins);
            if (do_wr && c == wr_cyc) model_write(wa, wd, wf);
            tick();
            wr_en        = 1'b0;
            fault_inject = 1'b0;
        end
        check("resp_valid_latency", {31'b0, resp_valid}, 32'd1);
        check("resp_instr", resp_instr, e_ins);
        check("resp_err", {31'b0, resp_err}, {31'b0, e_err});
        check("req_ready_resp", {31'b0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_instr", resp_instr, e_ins);
            check("hold_err", {31'b0, resp_err}, {31'b0, e_err});
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        if (e_err && m_errs < 255) m_errs++;
        check("post_valid", {31'b0, resp_valid}, 32'd0);
        check("post_req_ready", {31'b0, req_ready}, 32'd1);
        check("err_count", {24'b0, err_count}, 32'(m_errs));
    endtask

    task automatic load_program();
        write_word(0, 32'h002081B3, 1'b0);
        write_word(1, 32'h40208233, 1'b0);
        write_word(2, 32'h00000013, 1'b0);
        write_word(3, 32'hFFFFFFFF, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        model_reset();

        // Reset values
        #1;
        rst = 1'b1;
        #2;
        check("reset_resp_instr", resp_instr, 32'd0);
        check("reset_resp_err", {31'b0, resp_err}, 32'd0);
        reset_pulse();

        // Basic fetch and simple errors
        load_program();
        fetch(32'h4, 0, 1'b0, 0, 0, 0, 1'b0);
        check("first_fetch_count", {24'b0, err_count}, 32'd0);
        fetch(32'h2, 0, 1'b0, 0, 0, 0, 1'b0);
        fetch(32'h40, 0, 1'b0, 0, 0, 0, 1'b0);
        check("range_err_count", {24'b0, err_count}, 32'd2);

        // Unwritten, fault-injected, then repaired word
        reset_pulse();
        fetch(32'h14, 0, 1'b0, 0, 0, 0, 1'b0);
        write_word(5, 32'h00A50533, 1'b1);
        fetch(32'h14, 0, 1'b0, 0, 0, 0, 1'b0);
        write_word(5, 32'h00A50533, 1'b0);
        fetch(32'h14, 0, 1'b0, 0, 0, 0, 1'b0);
        check("repaired_err_count", {24'b0, err_count}, 32'd2);

        // Back-pressure for 5 cycles
        load_program();
        fetch(32'h0, 5, 1'b0, 0, 0, 0, 1'b0);

        // Write on the evaluation edge returns the old word; the next fetch sees the new one
        fetch(32'h4, 0, 1'b1, LATENCY - 1, 1, 32'hDEADBEEF, 1'b0);
        fetch(32'h4, 0, 1'b0, 0, 0, 0, 1'b0);
        // Write in an earlier WAIT cycle is visible
        fetch(32'h8, 0, 1'b1, 0, 2, 32'h12345678, 1'b0);

        // Reset during WAIT aborts the transaction
        req_valid = 1'b1;
        req_addr  = 32'h3;
        tick();
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        check("abort_err_count", {24'b0, err_count}, 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
            check("abort_idle_ready", {31'b0, req_ready}, 32'd1);
        end

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 1) == 0)
                write_word(int'($urandom_range(0, DEPTH - 1)), $urandom,
                           ($urandom_range(0, 3) == 0));
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            end else if (r == 1) begin
                a = (DEPTH + $urandom_range(0, 1000)) << 2;
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            end
            fetch(a, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, LATENCY - 1)), int'($urandom_range(0, DEPTH - 1)),
                  $urandom, ($urandom_range(0, 3) == 0));
        end

        // Saturation of the error counter
        reset_pulse();
        for (int i = 0; i < 256; i++) begin
            fetch(32'h1 + 32'(i % 3), 0, 1'b0, 0, 0, 0, 1'b0);
        end
        check("err_count_saturated", {24'b0, err_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder at the far end of the control subsystem's fetch interface. It accepts PC fetch requests on a valid/ready handshake and returns the instruction word after a programmable latency. Each stored word carries a parity bit and a written flag, so the core gets a defined NOP plus an error flag instead of corrupt or uninitialised opcodes. A separate write port loads programs; a fault-inject input lets benches corrupt stored parity.

Parameters:
DEPTH, 16, number of 32-bit instruction words (power of 2)
ADDR_W, 4, word-index width, equal to log2(DEPTH)
LATENCY, 2, cycles from request acceptance to resp_valid (legal range 1..15)
NOP_INSTR, 32'h00000013, word returned on any error (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address (PC)
resp_valid  output  1  response word available
resp_ready  input  1  consumer accepts the response
resp_instr  output  32  fetched instruction, or NOP_INSTR on error
resp_err  output  1  misaligned, out-of-range, unwritten or parity-fail
wr_en  input  1  program-load write strobe
wr_addr  input  ADDR_W  word index to write
wr_data  input  32  instruction word to store
fault_inject  input  1  when high with wr_en, the stored parity bit is inverted
err_count  output  8  saturating count of error responses delivered

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_instr=0, resp_err=0, err_count=0.
  - All per-word written flags clear. Data and parity arrays are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid, capture req_addr, load cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0, evaluate the captured address, register resp_instr and resp_err, set resp_valid=1 and go to RESP.
  - Result: resp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1; resp_instr and resp_err are held stable until resp_ready.
  - On resp_valid&&resp_ready: drop resp_valid, increment err_count if resp_err (saturates at 255), go to IDLE.
  - req_ready is asserted again on the next cycle. There is no back-to-back acceptance, so at most one request is outstanding.
- Error evaluation, in priority order:
  1. addr[1:0]!=0 (misaligned)
  2. addr[31:2] >= DEPTH (out of range)
  3. word not written since reset
  4. stored parity != ^data (parity fail)
  Any error gives resp_err=1 and resp_instr=NOP_INSTR. Otherwise resp_err=0 and resp_instr=data.
- Parity is even, i.e. parity bit = ^wr_data. It is computed at write time and inverted when fault_inject=1.
- Writes:
  - Accepted in every state.
  - Set the word's written flag; a rewrite with fault_inject=0 clears an injected fault.
  - A write to the word being evaluated in the same cycle as WAIT->RESP is read-before-write: the response carries the old content.
  - A write in any earlier WAIT cycle is seen by the response.
- Reset asserted mid-transaction aborts it: no response is produced and the request is dropped.
- Address index is addr[ADDR_W+1:2]; the upper bits are used only for the range check.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - NOP_INSTR constant
  - error-cause localparams (for waveform debug)
- One sub-module is natural: imem_parity_array, the DEPTH x 33-bit storage with written flags. It has a synchronous write port and a combinational read port.
- FSM, latency counter and err_count stay in the top.

Test Plan:
- Load words 0..3 with 32'h002081B3, 32'h40208233, 32'h00000013, 32'hFFFFFFFF; request addr 0x4 with resp_ready=1 -> resp_valid exactly 2 cycles after acceptance, resp_instr=32'h40208233, resp_err=0, err_count=0.
- Request addr 0x2 -> resp_err=1, resp_instr=32'h00000013, err_count=1. Then request addr 0x40 with DEPTH=16 -> resp_err=1, err_count=2.
- After reset, request unwritten word 5 -> resp_err=1, NOP. Then write word 5 with fault_inject=1 and request it -> resp_err=1. Rewrite with fault_inject=0 -> resp_err=0 with the data.
- Hold resp_ready=0 for 5 cycles -> resp_valid stays 1, resp_instr stable, req_ready=0. Release -> req_ready=1 on the following cycle.
- Write word 1 in the WAIT->RESP cycle of a fetch of 0x4 -> old word returned; the next fetch returns the new word.
- Assert rst during WAIT -> resp_valid=0 and req_ready=1 immediately, no response afterwards, err_count=0. With 256 error fetches, err_count saturates at 255.
